// File: rtl/spi_slave_pkg.sv
// Shared types and AXI response codes for the SPI->AXI write path.
package spi_slave_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, RESP} state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/spi_slave_axi_wr_drain.sv
// Drains header+data words from the CDC FIFO and issues one AXI4 single-beat
// write per data word, to consecutive addresses, one transaction at a time.
module spi_slave_axi_wr_drain
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   fifo_data_i,
    input  logic                    fifo_valid_i,
    output logic                    fifo_ready_o,
    input  logic [LEN_WIDTH-1:0]    cfg_len_i,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    done_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    fifo_ready_q, fifo_ready_d;
    logic                    b_ready_q, b_ready_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fifo_valid_i && fifo_ready_q) begin
                    addr_d = fifo_data_i[ADDR_WIDTH-1:0];
                    cnt_d  = cfg_len_i;
                    err_d  = 1'b0;
                    if (cfg_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (fifo_valid_i && fifo_ready_q) begin
                    data_d     = fifo_data_i;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Each channel retires on its own; leave only once both flags are registered.
                if (aw_valid_q && aw_ready_i) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_valid_q && w_ready_i) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_q && w_done_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_valid_i) begin
                    err_d  = err_q | (b_resp_i != AXI_RESP_OKAY);
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    addr_d = addr_q + ADDR_INC;
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so they are all low in reset.
        fifo_ready_d = (state_d == IDLE) || (state_d == FETCH);
        b_ready_d    = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            fifo_ready_q <= 1'b0;
            b_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            err_q        <= err_d;
            done_q       <= done_d;
            fifo_ready_q <= fifo_ready_d;
            b_ready_q    <= b_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign fifo_ready_o = fifo_ready_q;
    assign aw_addr_o    = addr_q;
    assign aw_valid_o   = aw_valid_q;
    assign w_data_o     = data_q;
    assign w_strb_o     = '1;
    assign w_valid_o    = w_valid_q;
    assign b_ready_o    = b_ready_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_spi_slave_axi_wr_drain.sv
// Directed bench: table of bursts against a small AXI slave model, plus a
// mid-transaction reset sequence.
module tb_spi_slave_axi_wr_drain;
    import spi_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] fifo_data_i = '0;
    logic        fifo_valid_i = 1'b0;
    logic        fifo_ready_o;
    logic [15:0] cfg_len_i = '0;
    logic [31:0] aw_addr_o;
    logic        aw_valid_o;
    logic        aw_ready_i = 1'b0;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_valid_o;
    logic        w_ready_i = 1'b0;
    logic [1:0]  b_resp_i = 2'b00;
    logic        b_valid_i = 1'b0;
    logic        b_ready_o;
    logic        busy_o;
    logic        err_o;
    logic        done_o;

    spi_slave_axi_wr_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_ready_o(fifo_ready_o),
        .cfg_len_i(cfg_len_i),
        .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .busy_o(busy_o), .err_o(err_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      hdr;
        logic [15:0]      len;
        logic [2:0][31:0] d;
        logic [2:0][1:0]  resp;
        logic [7:0]       awd;
        logic [7:0]       wd;
        logic [2:0][31:0] addr;
        logic [2:0]       errh;
        logic             err;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs[NVEC];

    // AXI slave model state
    int          aw_delay = 0, w_delay = 0;
    int          aw_cnt = 0, w_cnt = 0;
    bit          aw_hold = 0, w_hold = 0, aw_hsd = 0, w_hsd = 0, aw_got = 0, w_got = 0;
    bit          b_pend = 0, b_just = 0;
    logic [31:0] aw_hold_addr = '0, w_hold_data = '0;
    logic [1:0]  cur_resp = 2'b00;
    logic [1:0]  resp_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        err_hist[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 2'b00;
                aw_cnt = 0; w_cnt = 0; aw_hold = 0; w_hold = 0; aw_hsd = 0; w_hsd = 0;
                aw_got = 0; w_got = 0; b_pend = 0; b_just = 0;
                continue;
            end
            if (b_just) begin
                err_hist.push_back(err_o);
                b_just = 0;
            end
            if (b_pend) begin
                b_valid_i = 1; b_resp_i = cur_resp;
                if (b_ready_o) begin b_pend = 0; b_just = 1; end
            end else begin
                b_valid_i = 0; b_resp_i = 2'b00;
            end

            aw_ready_i = 0;
            if (aw_hsd) begin
                chk("aw_valid_drop_after_hs", 32'(aw_valid_o), 32'd0);
                aw_hsd = 0;
            end else if (aw_valid_o || aw_hold) begin
                if (aw_hold) begin
                    chk("aw_valid_held", 32'(aw_valid_o), 32'd1);
                    chk("aw_addr_stable", aw_addr_o, aw_hold_addr);
                end
                if (aw_valid_o) begin
                    if (aw_cnt >= aw_delay) begin
                        aw_ready_i = 1; aw_hsd = 1; aw_hold = 0; aw_cnt = 0; aw_got = 1;
                        wr_addr_q.push_back(aw_addr_o);
                    end else begin
                        aw_cnt++; aw_hold = 1; aw_hold_addr = aw_addr_o;
                    end
                end else aw_hold = 0;
            end

            w_ready_i = 0;
            if (w_hsd) begin
                chk("w_valid_drop_after_hs", 32'(w_valid_o), 32'd0);
                w_hsd = 0;
            end else if (w_valid_o || w_hold) begin
                if (w_hold) begin
                    chk("w_valid_held", 32'(w_valid_o), 32'd1);
                    chk("w_data_stable", w_data_o, w_hold_data);
                end
                if (w_valid_o) begin
                    if (w_cnt >= w_delay) begin
                        w_ready_i = 1; w_hsd = 1; w_hold = 0; w_cnt = 0; w_got = 1;
                        wr_data_q.push_back(w_data_o);
                    end else begin
                        w_cnt++; w_hold = 1; w_hold_data = w_data_o;
                    end
                end else w_hold = 0;
            end

            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1;
                cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : AXI_RESP_OKAY;
            end
        end
    end

    // done/busy monitor
    int done_cnt = 0;
    bit done_prev = 0, busy_seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin done_prev = 0; continue; end
            if (done_o) begin
                done_cnt++;
                chk("done_single_cycle", 32'(done_prev), 32'd0);
            end
            if (busy_o) busy_seen = 1;
            done_prev = done_o;
        end
    end

    task automatic push(input logic [31:0] d);
        fifo_valid_i = 1; fifo_data_i = d;
        for (int i = 0; i < 200; i++) begin
            if (fifo_ready_o) begin
                @(posedge clk);
                @(negedge clk);
                fifo_valid_i = 0;
                return;
            end
            @(negedge clk);
        end
        fifo_valid_i = 0;
        chk("fifo_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_vec(input int idx, input logic [31:0] hdr, input logic [15:0] len,
                           input logic [31:0] d0, d1, d2, input logic [1:0] r0, r1, r2,
                           input int awd, wd, input logic [31:0] a0, a1, a2,
                           input logic [2:0] errh, input logic err);
        vecs[idx].hdr = hdr;  vecs[idx].len = len;
        vecs[idx].d[0] = d0;  vecs[idx].d[1] = d1;  vecs[idx].d[2] = d2;
        vecs[idx].resp[0] = r0; vecs[idx].resp[1] = r1; vecs[idx].resp[2] = r2;
        vecs[idx].awd = 8'(awd); vecs[idx].wd = 8'(wd);
        vecs[idx].addr[0] = a0; vecs[idx].addr[1] = a1; vecs[idx].addr[2] = a2;
        vecs[idx].errh = errh; vecs[idx].err = err;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int   d0;
        int   n;
        v = vecs[vi];
        n = int'(v.len);
        aw_delay = int'(v.awd); w_delay = int'(v.wd);
        wr_addr_q.delete(); wr_data_q.delete(); err_hist.delete(); resp_q.delete();
        for (int i = 0; i < n; i++) resp_q.push_back(v.resp[i]);
        busy_seen = 0;
        d0 = done_cnt;
        cfg_len_i = v.len;
        push(v.hdr);
        cfg_len_i = 16'hFFFF;
        for (int i = 0; i < n; i++) push(v.d[i]);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_count", vi), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("v%0d_aw_count", vi), 32'(wr_addr_q.size()), 32'(n));
        chk($sformatf("v%0d_w_count", vi), 32'(wr_data_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size() && i < wr_data_q.size(); i++) begin
            chk($sformatf("v%0d_addr%0d", vi, i), wr_addr_q[i], v.addr[i]);
            chk($sformatf("v%0d_data%0d", vi, i), wr_data_q[i], v.d[i]);
        end
        chk($sformatf("v%0d_err_hist_count", vi), 32'(err_hist.size()), 32'(n));
        for (int i = 0; i < n && i < err_hist.size(); i++)
            chk($sformatf("v%0d_err_after_b%0d", vi, i), 32'(err_hist[i]), 32'(v.errh[i]));
        chk($sformatf("v%0d_err_held", vi), 32'(err_o), 32'(v.err));
        chk($sformatf("v%0d_busy_seen", vi), 32'(busy_seen), 32'(n != 0));
        chk($sformatf("v%0d_idle_ready", vi), {30'd0, busy_o, fifo_ready_o}, 32'd1);
    endtask

    initial begin
        //       idx hdr           len d0            d1            d2            r0    r1    r2    awd wd a0            a1            a2            errh    err
        set_vec(0, 32'h1000_0000, 3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 2'b00, 2'b00, 2'b00, 0, 0,
                32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 3'b000, 1'b0);
        set_vec(1, 32'h2000_0010, 2, 32'h1111_1111, 32'h2222_2222, 32'h0, 2'b00, 2'b00, 2'b00, 3, 0,
                32'h2000_0010, 32'h2000_0014, 32'h0, 3'b000, 1'b0);
        set_vec(2, 32'h2000_0100, 2, 32'h3333_3333, 32'h4444_4444, 32'h0, 2'b00, 2'b00, 2'b00, 0, 3,
                32'h2000_0100, 32'h2000_0104, 32'h0, 3'b000, 1'b0);
        set_vec(3, 32'hFFFF_FFFC, 2, 32'h5555_5555, 32'h6666_6666, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0,
                32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 3'b000, 1'b0);
        set_vec(4, 32'h3000_0000, 3, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999,
                2'b00, AXI_RESP_SLVERR, 2'b00, 0, 0,
                32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 3'b110, 1'b1);
        set_vec(5, 32'h0000_0ABC, 0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0,
                32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        set_vec(6, 32'h0000_0040, 1, 32'hCAFE_F00D, 32'h0, 32'h0, 2'b11, 2'b00, 2'b00, 2, 2,
                32'h0000_0040, 32'h0, 32'h0, 3'b001, 1'b1);

        repeat (2) @(negedge clk);
        chk("rst_fifo_ready", 32'(fifo_ready_o), 32'd0);
        chk("rst_aw_valid", 32'(aw_valid_o), 32'd0);
        chk("rst_w_valid", 32'(w_valid_o), 32'd0);
        chk("rst_b_ready", 32'(b_ready_o), 32'd0);
        chk("rst_busy_err_done", {29'd0, busy_o, err_o, done_o}, 32'd0);
        chk("rst_aw_addr", aw_addr_o, 32'd0);
        chk("rst_w_data", w_data_o, 32'd0);
        chk("rst_w_strb", 32'(w_strb_o), 32'hF);
        rstn = 1;
        @(negedge clk);
        chk("post_rst_fifo_ready", 32'(fifo_ready_o), 32'd1);

        for (int vi = 0; vi < NVEC; vi++) run_vec(vi);

        // Reset while both channels are stalled in SEND
        aw_delay = 50; w_delay = 50;
        cfg_len_i = 16'd2;
        push(32'h4000_0000);
        cfg_len_i = 16'hFFFF;
        push(32'hDEAD_BEEF);
        chk("send_aw_valid", 32'(aw_valid_o), 32'd1);
        chk("send_w_valid", 32'(w_valid_o), 32'd1);
        #2 rstn = 0;
        #1;
        chk("midrst_aw_valid", 32'(aw_valid_o), 32'd0);
        chk("midrst_w_valid", 32'(w_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_fifo_ready", 32'(fifo_ready_o), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("after_rst_idle_ready", {30'd0, busy_o, fifo_ready_o}, 32'd1);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
